// File: rtl/bcd_serial_sub.sv
// Digit-serial packed-BCD subtractor: A - B - Bin, one digit per clock, least-significant first.
// Define SUB_MAG_EN to add a FIX pass that turns a negative result into magnitude plus neg flag.
module bcd_serial_sub #(
  parameter int unsigned NDIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NDIGITS-1:0] A,
  input  logic [4*NDIGITS-1:0] B,
  input  logic                 Bin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NDIGITS-1:0] result,
  output logic                 borrow_out,
  output logic                 err,
  output logic                 neg
);

  localparam int unsigned W    = 4 * NDIGITS;
  localparam int unsigned IdxW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NDIGITS - 1);

`ifdef SUB_MAG_EN
  typedef enum logic [1:0] {StIdle, StSub, StFix, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StSub, StDone} state_e;
`endif

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W-1:0]    result_q, result_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            brw_q, brw_d;
  logic            borrow_q, borrow_d;
  logic            err_q, err_d;
  logic            neg_q, neg_d;

  logic [IdxW+1:0] lsb;
  logic [3:0]      minu, subt, digit;
  logic [4:0]      t;
  logic            brw_nx, bad, in_fix, last, accept;

`ifdef SUB_MAG_EN
  assign in_fix = (state_q == StFix);
`else
  assign in_fix = 1'b0;
`endif

  // Shared digit datapath; the FIX pass computes 0 - result to recover the magnitude.
  assign lsb    = {idx_q, 2'b00};
  assign minu   = in_fix ? 4'd0 : a_q[lsb +: 4];
  assign subt   = in_fix ? result_q[lsb +: 4] : b_q[lsb +: 4];
  assign t      = {1'b0, minu} - {1'b0, subt} - {4'b0000, brw_q};
  assign brw_nx = t[4];
  assign digit  = t[4] ? (t[3:0] + 4'd10) : t[3:0];
  assign bad    = ~in_fix & ((minu > 4'd9) | (subt > 4'd9));
  assign last   = (idx_q == LastIdx);
  assign accept = start & ((state_q == StIdle) | (state_q == StDone));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    brw_d    = brw_q;
    idx_d    = idx_q;
    result_d = result_q;
    borrow_d = borrow_q;
    err_d    = err_q;
    neg_d    = neg_q;

    case (state_q)
      StSub: begin
        result_d[lsb +: 4] = digit;
        brw_d = brw_nx;
        err_d = err_q | bad;
        idx_d = idx_q + IdxW'(1);
        if (last) begin
          idx_d    = '0;
          borrow_d = brw_nx;
          state_d  = StDone;
          if (err_d) begin
            result_d = '0;
          end
`ifdef SUB_MAG_EN
          else if (brw_nx) begin
            state_d = StFix;
            brw_d   = 1'b0;
            neg_d   = 1'b1;
          end
`endif
        end
      end
`ifdef SUB_MAG_EN
      StFix: begin
        result_d[lsb +: 4] = digit;
        brw_d = brw_nx;
        idx_d = idx_q + IdxW'(1);
        if (last) begin
          idx_d   = '0;
          state_d = StDone;
        end
      end
`endif
      StDone:  state_d = StIdle;
      default: ;
    endcase

    if (accept) begin
      a_d      = A;
      b_d      = B;
      brw_d    = Bin;
      idx_d    = '0;
      result_d = '0;
      borrow_d = 1'b0;
      err_d    = 1'b0;
      neg_d    = 1'b0;
      state_d  = StSub;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      brw_q    <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      brw_q    <= brw_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      borrow_q <= borrow_d;
      err_q    <= err_d;
      neg_q    <= neg_d;
    end
  end

  assign busy       = (state_q == StSub) | in_fix;
  assign done       = (state_q == StDone);
  assign result     = result_q;
  assign borrow_out = borrow_q;
  assign err        = err_q;
  assign neg        = neg_q;

endmodule
